// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and encodings for the pipeline hazard controller
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CNT_W = 16;

  // MEM wins over WB because it carries the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_MEM;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - saturating event counter with synchronous clear
import riscv_pkg::*;

module sat_counter16 (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control with multi-cycle EX sequencing
import riscv_pkg::*;

module hazard_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             mem_read_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_write_M,
  input  logic             reg_write_W,
  input  logic             pc_redirect_E,
  input  logic             mc_start_E,
  input  logic [5:0]       mc_cycles,
  input  logic             clr_cnt,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwdA_E,
  output logic [1:0]       fwdB_E,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  mc_state_t  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       mc_stall;
  logic       load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle that launches an op already stalls, so BUSY covers mc_cycles-2 more.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_stall  = 1'b0;
    mc_busy   = 1'b0;
    mc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mc_start_E && !pc_redirect_E) begin
          if (mc_cycles >= 6'd2) begin
            mc_stall = 1'b1;
            if (mc_cycles == 6'd2) begin
              state_nxt = DONE;
            end else begin
              state_nxt = BUSY;
              cnt_nxt   = mc_cycles - 6'd2;
            end
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      BUSY: begin
        mc_stall = 1'b1;
        mc_busy  = 1'b1;
        if (cnt == 6'd1) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      DONE: begin
        mc_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      mc_stall = 1'b0;
      mc_busy  = 1'b0;
      mc_done  = 1'b0;
    end
  end

  // Load-use only applies when no multi-cycle op owns EX.
  assign load_use = mem_read_E && (rd_E != 5'd0) && (state == IDLE) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (pc_redirect_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (mc_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  assign fwdA_E = fwd_sel(rs1_E, rd_M, reg_write_M, rd_W, reg_write_W);
  assign fwdB_E = fwd_sel(rs2_E, rd_M, reg_write_M, rd_W, reg_write_W);

  sat_counter16 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (stall_F),
    .count (stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (pc_redirect_E),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Reset rst, asynchronous, active-low; clock clk.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  async active-low reset.
REQ-004 rs1_D, rs2_D  in  5 each  source regs of instruction in decode.
REQ-005 rs1_E, rs2_E, rd_E  in  5 each  source/dest regs held in the ID/EX register.
REQ-006 mem_read_E  in  1  EX instruction is a load.
REQ-007 rd_M, rd_W  in  5 each  dest regs in MEM and WB.
REQ-008 reg_write_M, reg_write_W  in  1 each  write-enables in MEM and WB.
REQ-009 pc_redirect_E  in  1  taken branch, JAL or JALR resolved in EX.
REQ-010 mc_start_E  in  1  multi-cycle ALU op present in EX.
REQ-011 mc_cycles  in  6  total EX occupancy of that op, in cycles.
REQ-012 clr_cnt  in  1  synchronous clear of both perf counters.
REQ-013 stall_F, stall_D, stall_E  out  1 each  hold PC, IF/ID and ID/EX respectively.
REQ-014 flush_D, flush_E  out  1 each  zero IF/ID and ID/EX respectively.
REQ-015 fwdA_E, fwdB_E  out  2 each  operand-forwarding select: 00 regfile, 01 WB, 10 MEM.
REQ-016 mc_busy, mc_done  out  1 each  multi-cycle op in progress / final cycle.
REQ-017 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-018 Load-use hazard: mem_read_E=1, rd_E!=0 and rd_E equal to rs1_D or rs2_D.
REQ-019 On a load-use hazard, stall_F, stall_D and flush_E SHALL be 1 in the same cycle (combinational).
REQ-020 On pc_redirect_E=1, flush_D and flush_E SHALL be 1 in the same cycle, and all stalls SHALL be 0.
REQ-021 Priority, highest first: redirect, then an active multi-cycle stall, then load-use.
REQ-022 While a multi-cycle stall is active, flush_E SHALL be 0 and load-use SHALL be suppressed.
REQ-023 Forwarding for fwdA_E (fwdB_E uses rs2_E):
- 10 if reg_write_M=1, rd_M!=0 and rd_M==rs1_E;
- else 01 if reg_write_W=1, rd_W!=0 and rd_W==rs1_E;
- else 00.
- Output is combinational.
REQ-024 The multi-cycle FSM SHALL have states IDLE, BUSY and DONE.
REQ-025 IDLE with mc_start_E=1, no redirect and mc_cycles>=2:
- stall_F, stall_D and stall_E = 1 in this cycle;
- if mc_cycles==2, next state is DONE;
- otherwise next state is BUSY with cnt=mc_cycles-2.
REQ-026 IDLE with mc_start_E=1 and mc_cycles<=1: no stall, mc_done=1 for that cycle, remain in IDLE.
REQ-027 BUSY:
- stall_F, stall_D, stall_E and mc_busy = 1;
- if cnt==1, next state is DONE;
- otherwise cnt decrements.
REQ-028 DONE:
- all stalls = 0, mc_done = 1;
- next state is IDLE unconditionally;
- mc_start_E is ignored in this cycle.
REQ-029 The total stall length of a multi-cycle op SHALL be exactly mc_cycles-1 cycles.
REQ-030 A simultaneous mc_start_E and pc_redirect_E in IDLE SHALL be treated as a redirect; the FSM stays in IDLE.
REQ-031 stall_cnt SHALL increment on every cycle with stall_F=1 and saturate at 16'hFFFF.
REQ-032 flush_cnt SHALL increment on every cycle with pc_redirect_E=1 and saturate at 16'hFFFF.
REQ-033 clr_cnt=1 SHALL zero both counters on the next edge, overriding any increment.

Reset
REQ-034 rst=0 SHALL immediately force: state=IDLE, cnt=0, stall_cnt=0, flush_cnt=0, mc_busy=0 and mc_done=0.
REQ-035 With all inputs at 0, every output SHALL be 0.
REQ-036 Reset asserted while in BUSY SHALL abort the op; no mc_done is produced.

Structure
REQ-037 Package riscv_pkg SHALL hold:
- the FSM state enum;
- FWD_REG, FWD_WB and FWD_MEM encodings;
- the counter width constant.
REQ-038 One sub-module, sat_counter16 (increment, sync clear, saturate), SHALL be instantiated twice.
REQ-039 Hazard and forwarding logic SHALL be combinational; only the FSM, cnt and the counters SHALL be registered.

Verification
REQ-040 The bench SHALL cover the following directed scenarios:
- Load-use: mem_read_E=1, rd_E=5, rs2_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; stall_cnt=1.
- Redirect priority: redirect together with load-use -> flush_D=flush_E=1, stall_F=0; flush_cnt=1.
- Multi-cycle: mc_start_E=1, mc_cycles=5 -> stall_E high 4 cycles, mc_done in cycle 5, then IDLE; mc_cycles=2 -> 1 stall then DONE; mc_cycles=1 -> no stall, mc_done same cycle.
- Forwarding: rd_M=rd_W=rs1_E=7, both write-enables set -> fwdA_E=10; drop reg_write_M -> 01; rs1_E=0 -> 00.
- Reset mid-BUSY and saturation: rst low in cycle 2 of a mc_cycles=10 op -> IDLE, no mc_done; stall_cnt preloaded to FFFF with stall held -> stays FFFF; clr_cnt -> 0.
